apb_protocol_slave: RTL and testbench

APB_PROTOCOL_SLAVE -- requirements
Module: apb_protocol_slave

---
 rtl/apb_protocol_slave.sv | 173 +++++++++++++++++
 tb/tb_apb_protocol_slave.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/apb_protocol_slave.sv
// ---------------------------------------------------------------------------
// apb_protocol_slave
//   APB-style register slave. It holds NUM_REGS 8-bit registers at addresses
//   0..NUM_REGS-1. The top address is a read-only ID register. Every access
//   is stretched by WAIT_CYCLES wait states.
//
//   Transfer sequence as seen from this slave:
//     IDLE  --(psel & !penable)-->  SETUP   address/direction/data latched
//     SETUP --(psel &  penable)-->  ACCESS  wait counter loaded
//     ACCESS: pready once the counter reaches 0; a write commits on that edge
//
// Ports
//   pclk      in   clock, rising edge
//   presetn   in   asynchronous reset, active-high (1 = reset)
//   psel      in   slave select
//   penable   in   access-phase strobe
//   pwrite    in   1 = write, 0 = read
//   padd      in   [7:0] address
//   pwdata    in   [7:0] write data
//   prdata    out  [7:0] read data (0x00 outside reads)
//   pready    out  transfer completion
//   pslverr   out  transfer error, qualified by pready
// ---------------------------------------------------------------------------
module apb_protocol_slave #(
    parameter int         NUM_REGS    = 16,
    parameter int         WAIT_CYCLES = 1,
    parameter logic [7:0] ID_VALUE    = 8'hA5
) (
    input  logic       pclk,
    input  logic       presetn,
    input  logic       psel,
    input  logic       penable,
    input  logic       pwrite,
    input  logic [7:0] padd,
    input  logic [7:0] pwdata,
    output logic [7:0] prdata,
    output logic       pready,
    output logic       pslverr
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_cnt;
    logic [7:0] r_addr;
    logic [7:0] r_wdata;
    logic       r_write;
    logic       r_err;
    logic [7:0] r_prdata;
    logic [7:0] r_regs [NUM_REGS-1];

    logic       w_ready;
    logic       w_setup_edge;
    logic       w_access_edge;
    logic       w_commit;
    logic       w_setup_err;
    logic [7:0] w_rd_val;

    // Completion is decoded purely from flops, so no input reaches pready.
    assign w_ready = (r_state == ACCESS) && (r_cnt == 4'd0);
    assign pready  = w_ready;
    assign pslverr = w_ready && r_err;
    assign prdata  = r_prdata;

    // Entering SETUP from IDLE or, back-to-back, from a completed ACCESS.
    assign w_setup_edge  = (w_next == SETUP) && (r_state != SETUP);
    assign w_access_edge = (r_state == SETUP) && (w_next == ACCESS);
    assign w_commit      = w_ready && psel && penable && r_write && !r_err;

    // Error is known at setup time: out of range, or a write to the ID register.
    assign w_setup_err = ({1'b0, padd} >= 9'(NUM_REGS)) ||
                         (pwrite && (padd == 8'(NUM_REGS-1)));

    // Read mux; out-of-range addresses fall through to 0x00.
    always_comb begin
        w_rd_val = 8'h00;
        for (int i = 0; i < NUM_REGS-1; i++) begin
            if (padd == 8'(i)) begin
                w_rd_val = r_regs[i];
            end
        end
        if (padd == 8'(NUM_REGS-1)) begin
            w_rd_val = ID_VALUE;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                // penable without a setup cycle is ignored here.
                if (psel && !penable) begin
                    w_next = SETUP;
                end
            end
            SETUP: begin
                if (!psel) begin
                    w_next = IDLE;
                end else if (penable) begin
                    w_next = ACCESS;
                end
            end
            ACCESS: begin
                if (!psel || !penable) begin
                    // Before pready this is an abort; after it, a new setup
                    // may start straight away.
                    w_next = (w_ready && psel && !penable) ? SETUP : IDLE;
                end else if (w_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge pclk or posedge presetn) begin
        if (presetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge pclk or posedge presetn) begin
        if (presetn) begin
            r_cnt    <= 4'd0;
            r_addr   <= 8'h00;
            r_wdata  <= 8'h00;
            r_write  <= 1'b0;
            r_err    <= 1'b0;
            r_prdata <= 8'h00;
        end else begin
            if (w_setup_edge) begin
                r_addr   <= padd;
                r_wdata  <= pwdata;
                r_write  <= pwrite;
                r_err    <= w_setup_err;
                r_prdata <= pwrite ? 8'h00 : w_rd_val;
            end else if (w_next == IDLE) begin
                r_prdata <= 8'h00;
            end

            if (w_access_edge) begin
                r_cnt <= 4'(WAIT_CYCLES);
            end else if ((r_state == ACCESS) && (w_next == ACCESS) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end else if (w_next != ACCESS) begin
                r_cnt <= 4'd0;
            end
        end
    end

    // Writable registers; only a completing, error-free write touches them.
    always_ff @(posedge pclk or posedge presetn) begin
        if (presetn) begin
            for (int i = 0; i < NUM_REGS-1; i++) begin
                r_regs[i] <= 8'h00;
            end
        end else if (w_commit) begin
            for (int i = 0; i < NUM_REGS-1; i++) begin
                if (r_addr == 8'(i)) begin
                    r_regs[i] <= r_wdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_apb_protocol_slave.sv
module tb_apb_protocol_slave;

    logic       pclk;
    logic       rst;
    logic [2:0] psel;
    logic [2:0] penable;
    logic [2:0] pwrite;
    logic [7:0] padd   [3];
    logic [7:0] pwdata [3];
    logic [7:0] prdata [3];
    logic [2:0] pready;
    logic [2:0] pslverr;

    // Three slaves: wait states 1, 0 and 3.
    apb_protocol_slave #(.NUM_REGS(16), .WAIT_CYCLES(1), .ID_VALUE(8'hA5)) u_w1 (
        .pclk(pclk), .presetn(rst), .psel(psel[0]), .penable(penable[0]),
        .pwrite(pwrite[0]), .padd(padd[0]), .pwdata(pwdata[0]),
        .prdata(prdata[0]), .pready(pready[0]), .pslverr(pslverr[0]));
    apb_protocol_slave #(.NUM_REGS(16), .WAIT_CYCLES(0), .ID_VALUE(8'hA5)) u_w0 (
        .pclk(pclk), .presetn(rst), .psel(psel[1]), .penable(penable[1]),
        .pwrite(pwrite[1]), .padd(padd[1]), .pwdata(pwdata[1]),
        .prdata(prdata[1]), .pready(pready[1]), .pslverr(pslverr[1]));
    apb_protocol_slave #(.NUM_REGS(16), .WAIT_CYCLES(3), .ID_VALUE(8'hA5)) u_w3 (
        .pclk(pclk), .presetn(rst), .psel(psel[2]), .penable(penable[2]),
        .pwrite(pwrite[2]), .padd(padd[2]), .pwdata(pwdata[2]),
        .prdata(prdata[2]), .pready(pready[2]), .pslverr(pslverr[2]));

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    typedef struct {
        int         k;
        logic [7:0] d;
        logic       e;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   lat [3];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int waits_of(input int k);
        return (k == 0) ? 1 : (k == 1) ? 0 : 3;
    endfunction

    // Monitor: every pready presentation is matched against the scoreboard.
    // lat counts negedges with psel&penable, i.e. setup-follow cycle + A1.. .
    always @(negedge pclk) begin
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                lat[k] = 0;
            end else begin
                if (psel[k] && penable[k]) lat[k]++;
                if (pready[k]) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_pready", 1, 0);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        chk("slave_index", k, e.k);
                        chk("prdata", int'(prdata[k]), int'(e.d));
                        chk("pslverr", int'(pslverr[k]), int'(e.e));
                        chk("latency", lat[k], e.lat);
                    end
                end
                if (!(psel[k] && penable[k])) lat[k] = 0;
            end
        end
    end

    // Full transfer; returns #1 after the completion edge with the bus idle,
    // so a following call starts its setup with no idle cycle.
    task automatic xfer(input int k, input logic wr, input logic [7:0] a,
                        input logic [7:0] wd, input logic [7:0] ed, input logic ee);
        exp_t e;
        bit   seen;
        e.k = k; e.d = ed; e.e = ee; e.lat = waits_of(k) + 2;
        sb.push_back(e);
        psel[k] = 1'b1; penable[k] = 1'b0; pwrite[k] = wr;
        padd[k] = a; pwdata[k] = wd;
        @(posedge pclk); #1;
        penable[k] = 1'b1;
        padd[k] = ~a; pwdata[k] = ~wd;   // must be ignored after setup
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge pclk);
            if (pready[k]) seen = 1'b1;
        end
        if (!seen) chk("pready_timeout", 0, 1);
        @(posedge pclk); #1;
        psel[k] = 1'b0; penable[k] = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit any;
        exp_t e;
        rst = 1'b1;
        psel = '0; penable = '0; pwrite = '0;
        for (int k = 0; k < 3; k++) begin padd[k] = '0; pwdata[k] = '0; end
        repeat (2) @(negedge pclk);
        for (int k = 0; k < 3; k++) begin
            chk("reset_prdata", int'(prdata[k]), 0);
            chk("reset_pready", int'(pready[k]), 0);
            chk("reset_pslverr", int'(pslverr[k]), 0);
        end
        @(posedge pclk); #1;
        rst = 1'b0;
        @(posedge pclk); #1;

        // WAIT_CYCLES=1: basic write/read
        xfer(0, 1'b1, 8'h03, 8'hA5, 8'h00, 1'b0);
        xfer(0, 1'b0, 8'h03, 8'h00, 8'hA5, 1'b0);
        xfer(0, 1'b1, 8'h05, 8'hC3, 8'h00, 1'b0);
        xfer(0, 1'b0, 8'h05, 8'h00, 8'hC3, 1'b0);
        // error cases
        xfer(0, 1'b0, 8'h20, 8'h00, 8'h00, 1'b1);
        xfer(0, 1'b1, 8'h0F, 8'h11, 8'h00, 1'b1);
        xfer(0, 1'b0, 8'h0F, 8'h00, 8'hA5, 1'b0);
        xfer(0, 1'b1, 8'h10, 8'h99, 8'h00, 1'b1);
        xfer(0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);

        // WAIT_CYCLES=0: back-to-back
        xfer(1, 1'b1, 8'h01, 8'h5A, 8'h00, 1'b0);
        xfer(1, 1'b0, 8'h01, 8'h00, 8'h5A, 1'b0);
        @(posedge pclk); #1;

        // WAIT_CYCLES=3: abort by dropping psel in A1
        psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1;
        padd[2] = 8'h02; pwdata[2] = 8'h33;
        @(posedge pclk); #1;
        penable[2] = 1'b1;
        @(posedge pclk); #1;
        psel[2] = 1'b0; penable[2] = 1'b0;
        any = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge pclk);
            if (pready[2] || pslverr[2]) any = 1'b1;
        end
        chk("abort_no_pready", int'(any), 0);
        @(posedge pclk); #1;
        xfer(2, 1'b0, 8'h02, 8'h00, 8'h00, 1'b0);

        // Reset during the ready cycle of write 0x04 <- 0x77
        xfer(2, 1'b1, 8'h04, 8'h66, 8'h00, 1'b0);
        xfer(2, 1'b0, 8'h04, 8'h00, 8'h66, 1'b0);
        e.k = 2; e.d = 8'h00; e.e = 1'b0; e.lat = 5;
        sb.push_back(e);
        psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1;
        padd[2] = 8'h04; pwdata[2] = 8'h77;
        @(posedge pclk); #1;
        penable[2] = 1'b1;
        any = 1'b0;
        for (int i = 0; i < 30 && !any; i++) begin
            @(negedge pclk);
            if (pready[2]) any = 1'b1;
        end
        chk("rst_mid_reached_ready", int'(any), 1);
        #1 rst = 1'b1;
        #1;
        chk("rst_mid_pready", int'(pready[2]), 0);
        chk("rst_mid_pslverr", int'(pslverr[2]), 0);
        psel[2] = 1'b0; penable[2] = 1'b0;
        @(posedge pclk); #1;
        rst = 1'b0;
        @(posedge pclk); #1;
        xfer(2, 1'b0, 8'h04, 8'h00, 8'h00, 1'b0);

        // penable without a setup cycle is ignored
        psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b1;
        padd[0] = 8'h06; pwdata[0] = 8'hEE;
        any = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge pclk);
            if (pready[0]) any = 1'b1;
        end
        psel[0] = 1'b0;
        @(negedge pclk);
        if (pready[0]) any = 1'b1;
        chk("no_setup_no_pready", int'(any), 0);
        @(posedge pclk); #1;
        penable[0] = 1'b0;
        xfer(0, 1'b0, 8'h06, 8'h00, 8'h00, 1'b0);
        xfer(0, 1'b0, 8'h03, 8'h00, 8'h00, 1'b0);
        xfer(0, 1'b0, 8'h0F, 8'h00, 8'hA5, 1'b0);

        repeat (5) @(negedge pclk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
